// File: rtl/registrodesp_param.sv
// rtl/registrodesp_param.sv - parametrised universal shift register with auto-shift burst
module registrodesp_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             dir,
    input  logic             s_in,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [CNT_W-1:0] cnt,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;
    localparam logic [1:0] MODE_ARITH  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic [1:0]       lmode, lmode_n;
    logic             ldir, ldir_n;
    logic             done_n;
    logic             dir_eff;

    // Single-step register transform; dir=0 moves bits toward the MSB.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [WIDTH-1:0] cur,
        input logic [1:0]       op,
        input logic             rdir,
        input logic             sin,
        input logic [WIDTH-1:0] pdata
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (op)
            MODE_SHIFT:  r = rdir ? {sin, cur[WIDTH-1:1]} : {cur[WIDTH-2:0], sin};
            MODE_ROTATE: r = rdir ? {cur[0], cur[WIDTH-1:1]} : {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_LOAD:   r = pdata;
            MODE_ARITH:  r = rdir ? {cur[WIDTH-1], cur[WIDTH-1:1]} : {cur[WIDTH-2:0], 1'b0};
            default:     r = cur;
        endcase
        return r;
    endfunction

    // State register plus datapath registers; reset wins over everything, including mid-burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            rem   <= '0;
            lmode <= MODE_SHIFT;
            ldir  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            rem   <= rem_n;
            lmode <= lmode_n;
            ldir  <= ldir_n;
            done  <= done_n;
        end
    end

    // Next-state logic: manual ops in IDLE, latched-op countdown in BURST; enb=0 freezes both.
    always_comb begin
        state_n = state;
        q_n     = q;
        rem_n   = rem;
        lmode_n = lmode;
        ldir_n  = ldir;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (enb) begin
                    if (start && (cnt != '0) && (mode != MODE_LOAD)) begin
                        // Entry edge only captures the burst; q is left untouched.
                        state_n = BURST;
                        rem_n   = cnt;
                        lmode_n = mode;
                        ldir_n  = dir;
                    end else begin
                        q_n = apply_op(q, mode, dir, s_in, d);
                    end
                end
            end
            BURST: begin
                if (enb) begin
                    // s_in is sampled live so a shift burst can serialise fresh bits in.
                    q_n   = apply_op(q, lmode, ldir, s_in, d);
                    rem_n = rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Exit-end bit follows the direction actually in force this cycle.
    always_comb begin
        dir_eff = (state == BURST) ? ldir : dir;
        s_out   = dir_eff ? q[0] : q[WIDTH-1];
        busy    = (state == BURST);
    end

endmodule

// File: tb/tb_registrodesp_param.sv
// tb/tb_registrodesp_param.sv - scoreboard bench for registrodesp_param
module tb_registrodesp_param;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, enb, dir, s_in, start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q;
    logic             s_out, busy, done;

    registrodesp_param #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enb(enb), .dir(dir), .s_in(s_in), .mode(mode),
        .d(d), .cnt(cnt), .start(start), .q(q), .s_out(s_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int busy;
        int done;
        int s_out;
        int tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: plain integers, burst tracked as "shifts still owed".
    int  m_q     = 0;
    int  m_owed  = 0;
    int  m_done  = 0;
    int  m_lmode = 0;
    int  m_ldir  = 0;
    bit  m_valid = 0;
    int  tag     = 0;

    function automatic int step_val(int v, int op, int rd, int si, int pd);
        case (op)
            0: return rd ? (si * 128 + v / 2) : ((v * 2 + si) % 256);
            1: return rd ? ((v % 2) * 128 + v / 2) : ((v * 2) % 256 + v / 128);
            2: return pd;
            default: return rd ? ((v / 128) * 128 + v / 2) : ((v * 2) % 256);
        endcase
    endfunction

    function automatic void model_edge(int r, int e, int dr, int si, int md, int pd, int c, int st);
        int nd;
        if (r) begin
            m_q = 0; m_owed = 0; m_done = 0;
            return;
        end
        nd = 0;
        if (m_owed > 0) begin
            if (e) begin
                m_q = step_val(m_q, m_lmode, m_ldir, si, 0);
                m_owed--;
                if (m_owed == 0) nd = 1;
            end
        end else if (e) begin
            if (st && c != 0 && md != 2) begin
                m_owed = c; m_lmode = md; m_ldir = dr;
            end else begin
                m_q = step_val(m_q, md, dr, si, pd);
            end
        end
        m_done = nd;
    endfunction

    // One clock: apply inputs, queue what the DUT should show this cycle, then advance the model.
    task automatic cyc(int r, int e, int dr, int si, int md, int pd, int c, int st);
        exp_t x;
        int   de;
        rst = r[0]; enb = e[0]; dir = dr[0]; s_in = si[0];
        mode = md[1:0]; d = pd[WIDTH-1:0]; cnt = c[CNT_W-1:0]; start = st[0];
        if (m_valid) begin
            de      = (m_owed > 0) ? m_ldir : dr;
            x.q     = m_q;
            x.busy  = (m_owed > 0) ? 1 : 0;
            x.done  = m_done;
            x.s_out = de ? (m_q % 2) : (m_q / 128);
            x.tag   = tag;
            sb.push_back(x);
        end
        @(posedge clk);
        model_edge(r, e, dr, si, md, pd, c, st);
        if (r) m_valid = 1;
        tag++;
        #1;
    endtask

    task automatic chk(string name, int t, int act, int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, act, exp_v);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, pop one expectation and compare.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("q",     e.tag, int'(q),     e.q);
            chk("busy",  e.tag, int'(busy),  e.busy);
            chk("done",  e.tag, int'(done),  e.done);
            chk("s_out", e.tag, int'(s_out), e.s_out);
        end
    end

    initial begin
        // 1: reset, then parallel load A5
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 2, 'hA5, 0, 0);
        // 2: shift left s_in=1 -> 4B ; reload, shift right s_in=0 -> 52
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 2, 'hA5, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        // 3: rotate right A5 -> D2 ; arith right 90 -> C8 ; arith left 90 -> 20 ; hold
        cyc(0, 1, 0, 0, 2, 'hA5, 0, 0);
        cyc(0, 1, 1, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 2, 'h90, 0, 0);
        cyc(0, 1, 1, 0, 3, 0, 0, 0);
        cyc(0, 1, 0, 0, 2, 'h90, 0, 0);
        cyc(0, 1, 0, 0, 3, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 'hFF, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        // 4: rotate-left burst of 3 from 81, inputs scrambled during the burst
        cyc(0, 1, 0, 0, 2, 'h81, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 3, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 2, 'hFF, 7, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // 5: same burst with a one-cycle pause
        cyc(0, 1, 0, 0, 2, 'h81, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 3, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        // new start accepted during the done cycle (right shift burst, live s_in)
        cyc(0, 1, 1, 0, 0, 0, 2, 1);
        cyc(0, 1, 0, 1, 3, 0, 0, 0);
        cyc(0, 1, 0, 0, 3, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // 6: reset mid-burst, then ignored starts (cnt=0, mode=10, enb=0)
        cyc(0, 1, 0, 0, 2, 'h3C, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 5, 1);
        cyc(0, 1, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 2, 'h5A, 4, 1);
        cyc(0, 0, 0, 0, 1, 0, 4, 1);
        cyc(0, 1, 1, 0, 3, 0, 15, 1);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 59) == 0) ? 1 : 0,
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
